key_debounce_array: RTL



---
 rtl/key_pkg.sv | 15 +
 rtl/key_debounce_chan.sv | 113 +++++++++++
 rtl/key_debounce_array.sv | 42 ++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared constants and helpers for the key debouncer.
// Level encoding and counter-width sizing used by every channel.
package key_pkg;

  localparam logic KEY_PRESSED  = 1'b1;
  localparam logic KEY_RELEASED = 1'b0;

  // Counter width for a given terminal count; never narrower than one bit.
  function automatic int clog2_min1(input int value);
    int width;
    width = $clog2(value);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One debounced key channel: synchroniser, stable-time counter, level
// register with press/release pulses, and optional auto-repeat.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 32,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8192
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_debounce_chan: DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY > 0 && REPEAT_PERIOD < 1) begin : g_bad_period
    $error("key_debounce_chan: REPEAT_PERIOD must be at least 1 when auto-repeat is on");
  end

  localparam int CW = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          pressed_raw;
  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] db_count;
  logic          differs;
  logic          accept;

  assign pressed_raw = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;
  assign differs     = (sync_2 != key_level);
  assign accept      = differs && (db_count == DB_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= KEY_RELEASED;
      sync_2 <= KEY_RELEASED;
    end else begin
      sync_1 <= pressed_raw;
      sync_2 <= sync_1;
    end
  end

  // Any cycle agreeing with the accepted level restarts the stable-time count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_count <= '0;
    end else if (!differs || accept) begin
      db_count <= '0;
    end else begin
      db_count <= db_count + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_level     <= KEY_RELEASED;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      if (accept) begin
        key_level <= sync_2;
      end
      press_pulse   <= accept && (sync_2 == KEY_PRESSED);
      release_pulse <= accept && (sync_2 == KEY_RELEASED);
    end
  end

  if (REPEAT_DELAY > 0) begin : g_repeat
    localparam int HOLD_TOP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW = clog2_min1(HOLD_TOP + 1);
    localparam logic [HW-1:0] FIRST_LAST  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);
    localparam logic [HW-1:0] HOLD_SAT    = HW'(HOLD_TOP);

    logic [HW-1:0] hold_count;
    logic          periodic;
    logic          fire;

    // A release being accepted this cycle suppresses any repeat due now.
    assign fire = (key_level == KEY_PRESSED) && !accept &&
                  (hold_count == (periodic ? PERIOD_LAST : FIRST_LAST));

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        hold_count   <= '0;
        periodic     <= 1'b0;
        repeat_pulse <= 1'b0;
      end else begin
        repeat_pulse <= fire;
        if (accept || key_level != KEY_PRESSED) begin
          hold_count <= '0;
          periodic   <= 1'b0;
        end else if (fire) begin
          hold_count <= '0;
          periodic   <= 1'b1;
        end else if (hold_count != HOLD_SAT) begin
          hold_count <= hold_count + 1'b1;
        end
      end
    end
  end else begin : g_no_repeat
    assign repeat_pulse = 1'b0;
  end

endmodule

// File: rtl/key_debounce_array.sv
// N independent debounced key channels with press/release/repeat pulses,
// for the codec front panel and user keys.
module key_debounce_array
  import key_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 32,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8192
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);

  if (N_KEYS < 1 || N_KEYS > 32) begin : g_bad_keys
    $error("key_debounce_array: N_KEYS must be in 1..32");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clock        (clock),
      .reset_n      (reset_n),
      .key_raw      (key_raw[i]),
      .key_level    (key_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule
